// File: rtl/dcache_pkg.sv
// Shared data-cache types and address split helpers, used by the miss handler and data_cache
// so both agree on the index/tag layout.
package dcache_pkg;

  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CACHE_SIZE = 128;
  localparam int unsigned INDEX_W    = $clog2(CACHE_SIZE);
  localparam int unsigned TAG_W      = ADDR_W - INDEX_W;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    FILL,
    DONE
  } miss_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] wdata;
  } miss_req_t;

  // Line index: address modulo CACHE_SIZE (CACHE_SIZE is a power of two).
  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[INDEX_W-1:0];
  endfunction

  // Line tag: address divided by CACHE_SIZE.
  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:INDEX_W];
  endfunction

endpackage

// File: rtl/dcache_miss_handler.sv
// Single-outstanding miss/refill controller between the data cache and backing memory.
// Optional MISS_COUNTER_EN adds saturating miss_count / wr_miss_count outputs.
module dcache_miss_handler
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               miss_valid,
  output logic               miss_ready,
  input  logic [ADDR_W-1:0]  miss_addr,
  input  logic               miss_rw,
  input  logic [DATA_W-1:0]  miss_wdata,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  output logic               mem_req_we,
  output logic [DATA_W-1:0]  mem_req_wdata,
  input  logic               mem_rsp_valid,
  input  logic [DATA_W-1:0]  mem_rsp_data,
  output logic               fill_valid,
  output logic [INDEX_W-1:0] fill_index,
  output logic [TAG_W-1:0]   fill_tag,
  output logic [DATA_W-1:0]  fill_data,
  output logic               done_valid,
`ifdef MISS_COUNTER_EN
  output logic [CNT_W-1:0]   miss_count,
  output logic [CNT_W-1:0]   wr_miss_count,
`endif
  output logic [DATA_W-1:0]  done_data
);

  miss_state_t       state;
  miss_req_t         req;
  logic [DATA_W-1:0] line_data;

  // Request fields and fill split come straight from the latched miss, so they
  // stay stable for the whole transaction.
  assign mem_req_addr  = req.addr;
  assign mem_req_we    = req.rw;
  assign mem_req_wdata = req.wdata;
  assign fill_index    = addr_index(req.addr);
  assign fill_tag      = addr_tag(req.addr);
  assign fill_data     = line_data;
  assign done_data     = line_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      req           <= '0;
      line_data     <= '0;
      miss_ready    <= 1'b1;
      mem_req_valid <= 1'b0;
      fill_valid    <= 1'b0;
      done_valid    <= 1'b0;
    end else begin
      fill_valid <= 1'b0;
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_valid) begin
            req           <= '{addr: miss_addr, rw: miss_rw, wdata: miss_wdata};
            miss_ready    <= 1'b0;
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          // Any response arriving alongside the accept is dropped: it must follow it.
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (req.rw) begin
              line_data  <= req.wdata;
              fill_valid <= 1'b1;
              state      <= FILL;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            line_data  <= mem_rsp_data;
            fill_valid <= 1'b1;
            state      <= FILL;
          end
        end
        FILL: begin
          done_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          miss_ready <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          miss_ready    <= 1'b1;
          mem_req_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

`ifdef MISS_COUNTER_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating acceptance counters; acceptance happens only in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      miss_count    <= '0;
      wr_miss_count <= '0;
    end else if (state == IDLE && miss_valid) begin
      if (miss_count != CNT_MAX) miss_count <= miss_count + CNT_W'(1);
      if (miss_rw && wr_miss_count != CNT_MAX) wr_miss_count <= wr_miss_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Randomized self-checking bench for dcache_miss_handler; expectations come from a
// transaction-level model (address split by % and /, latency from the protocol's cycle rules).
module tb_dcache_miss_handler;
  import dcache_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               miss_valid;
  logic               miss_ready;
  logic [ADDR_W-1:0]  miss_addr;
  logic               miss_rw;
  logic [DATA_W-1:0]  miss_wdata;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_req_we;
  logic [DATA_W-1:0]  mem_req_wdata;
  logic               mem_rsp_valid;
  logic [DATA_W-1:0]  mem_rsp_data;
  logic               fill_valid;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic [DATA_W-1:0]  fill_data;
  logic               done_valid;
  logic [DATA_W-1:0]  done_data;
`ifdef MISS_COUNTER_EN
  logic [15:0]        miss_count;
  logic [15:0]        wr_miss_count;
`endif

  dcache_miss_handler dut (
    .clk           (clk),
    .reset         (reset),
    .miss_valid    (miss_valid),
    .miss_ready    (miss_ready),
    .miss_addr     (miss_addr),
    .miss_rw       (miss_rw),
    .miss_wdata    (miss_wdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_we    (mem_req_we),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .fill_valid    (fill_valid),
    .fill_index    (fill_index),
    .fill_tag      (fill_tag),
    .fill_data     (fill_data),
    .done_valid    (done_valid),
`ifdef MISS_COUNTER_EN
    .miss_count    (miss_count),
    .wr_miss_count (wr_miss_count),
`endif
    .done_data     (done_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int exp_misses = 0;
  int exp_wr_misses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One complete miss; entered and left just after a falling edge.
  task automatic run_miss(input logic [ADDR_W-1:0] addr, input logic rw,
                          input logic [DATA_W-1:0] wdata, input int rdy_dly,
                          input int rsp_dly, input logic [DATA_W-1:0] rsp, input bit noise);
    int unsigned a;
    int fills = 0;
    bit done_seen = 0;
    int exp_lat;
    int unsigned exp_index;
    int unsigned exp_tag;
    logic [DATA_W-1:0] exp_line;
    exp_index = int'(addr) % CACHE_SIZE;
    exp_tag   = int'(addr) / CACHE_SIZE;
    exp_line  = rw ? wdata : rsp;
    exp_lat   = rw ? (3 + rdy_dly) : (4 + rdy_dly + rsp_dly);

    check("ready_before_miss", 32'(miss_ready), 32'd1);
    miss_valid = 1'b1; miss_addr = addr; miss_rw = rw; miss_wdata = wdata;
    @(negedge clk);
    a = cyc;
    miss_valid = 1'b0;
    exp_misses++;
    if (rw) exp_wr_misses++;
    check("req_valid", 32'(mem_req_valid), 32'd1);
    check("req_addr", 32'(mem_req_addr), 32'(addr));
    check("req_we", 32'(mem_req_we), 32'(rw));
    if (rw) check("req_wdata", 32'(mem_req_wdata), 32'(wdata));
    check("ready_busy", 32'(miss_ready), 32'd0);

    for (int i = 0; i < rdy_dly; i++) begin
      if (noise) begin
        miss_valid    = 1'($urandom);
        miss_addr     = ADDR_W'($urandom);
        miss_rw       = 1'($urandom);
        mem_rsp_valid = 1'($urandom);
        mem_rsp_data  = DATA_W'($urandom);
      end
      @(negedge clk);
      check("req_hold_valid", 32'(mem_req_valid), 32'd1);
      check("req_hold_addr", 32'(mem_req_addr), 32'(addr));
      check("req_hold_we", 32'(mem_req_we), 32'(rw));
      check("busy_ready", 32'(miss_ready), 32'd0);
    end
    miss_valid    = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = noise && !rw;
    mem_rsp_data  = ~rsp;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    check("req_dropped", 32'(mem_req_valid), 32'd0);

    if (!rw) begin
      for (int i = 0; i < rsp_dly; i++) begin
        if (noise) begin
          miss_valid = 1'($urandom);
          miss_addr  = ADDR_W'($urandom);
        end
        @(negedge clk);
        check("wait_no_fill", 32'(fill_valid), 32'd0);
        check("wait_ready", 32'(miss_ready), 32'd0);
      end
      miss_valid    = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = rsp;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = DATA_W'($urandom);
    end

    for (int k = 0; k < 12 && !done_seen; k++) begin
      if (k > 0) @(negedge clk);
      if (fill_valid) begin
        fills++;
        check("fill_index", 32'(fill_index), exp_index);
        check("fill_tag", 32'(fill_tag), exp_tag);
        check("fill_data", 32'(fill_data), 32'(exp_line));
      end
      if (done_valid) begin
        done_seen = 1;
        check("done_data", 32'(done_data), 32'(exp_line));
        check("latency", 32'(cyc - a + 1), 32'(exp_lat));
      end
    end
    check("done_seen", 32'(done_seen), 32'd1);
    check("fill_once", 32'(fills), 32'd1);
    @(negedge clk);
    check("done_pulse_end", 32'(done_valid), 32'd0);
    check("ready_after_done", 32'(miss_ready), 32'd1);
  endtask

  // Reset while waiting for a read response must abandon the miss silently.
  task automatic reset_in_wait();
    miss_valid = 1'b1; miss_addr = 9'h0AA; miss_rw = 1'b0; miss_wdata = 8'h00;
    @(negedge clk);
    miss_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_misses = 0;
    exp_wr_misses = 0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 8'h99;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      check("rst_no_fill", 32'(fill_valid), 32'd0);
      check("rst_no_done", 32'(done_valid), 32'd0);
      check("rst_ready", 32'(miss_ready), 32'd1);
      check("rst_no_req", 32'(mem_req_valid), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    miss_valid = 1'b0; miss_addr = '0; miss_rw = 1'b0; miss_wdata = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (3) @(negedge clk);
    check("reset_miss_ready", 32'(miss_ready), 32'd1);
    check("reset_req_valid", 32'(mem_req_valid), 32'd0);
    check("reset_req_addr", 32'(mem_req_addr), 32'd0);
    check("reset_fill_valid", 32'(fill_valid), 32'd0);
    check("reset_done_valid", 32'(done_valid), 32'd0);
    check("reset_done_data", 32'(done_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_miss(9'h185, 1'b0, 8'h00, 0, 0, 8'hA5, 1'b0);
    run_miss(9'h07F, 1'b1, 8'h3C, 0, 0, 8'h00, 1'b0);
    run_miss(9'h123, 1'b0, 8'h00, 5, 3, 8'h5A, 1'b1);
    run_miss(9'h1FF, 1'b1, 8'hC3, 5, 0, 8'h00, 1'b1);
    run_miss(9'h000, 1'b0, 8'h00, 0, 0, 8'hFF, 1'b1);
    reset_in_wait();

    for (int n = 0; n < 40; n++) begin
      run_miss(ADDR_W'($urandom), 1'($urandom), DATA_W'($urandom),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
               DATA_W'($urandom), 1'($urandom));
    end

`ifdef MISS_COUNTER_EN
    check("miss_count", 32'(miss_count), 32'(exp_misses > 65535 ? 65535 : exp_misses));
    check("wr_miss_count", 32'(wr_miss_count), 32'(exp_wr_misses > 65535 ? 65535 : exp_wr_misses));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
